regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single write port of int_regfile between two writeback requesters: req0 (ALU) and req1 (LSU load return).
- Each requester uses a valid/ready handshake. The arbiter uses round-robin priority and drops writes to x0 without using the port.
- It drives the regfile write port (wen_in/waddr_in/wdata_in) from a registered output stage and keeps a running count of writes issued.

Parameters:
XLEN, 64, register data width; must match int_regfile XLEN.
CNT_W, 32, width of the write counter.

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst  input  1  synchronous, active-low reset (rst=0 at a rising edge resets).
stall_in  input  1  hazard/flush hold; when 1, no grants are issued.
req0_valid_in  input  1  ALU writeback request.
req0_addr_in  input  5  ALU destination register.
req0_data_in  input  XLEN  ALU result.
req0_ready_out  output  1  ALU request accepted this cycle (valid & ready).
req1_valid_in  input  1  LSU writeback request.
req1_addr_in  input  5  LSU destination register.
req1_data_in  input  XLEN  LSU load data.
req1_ready_out  output  1  LSU request accepted this cycle.
wen_out  output  1  to regfile wen_in.
waddr_out  output  5  to regfile waddr_in.
wdata_out  output  XLEN  to regfile wdata_in.
wr_count_out  output  CNT_W  number of regfile writes issued since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=0 at edge):
  - wen_out=0, waddr_out=0, wdata_out=0, wr_count_out=0.
  - Priority pointer prio=0 (req0 preferred).
  - Any write captured in the same cycle is discarded. Reset wins over every other event.
- Zero-address filter:
  - A valid request with addr==0 is always accepted in the same cycle (ready=1), even when stall_in=1.
  - It produces no write, is not a grant, does not change prio and does not increment the counter.
- Eligibility: requester i is eligible when valid_i=1, addr_i!=0 and stall_in=0.
- Grant rules (combinational):
  - Only one eligible requester: it is granted.
  - Both eligible: grant goes to prio.
  - None eligible: no grant.
- Ready rules:
  - ready_i=1 when requester i is granted or its valid request has addr==0, else 0.
  - A nonzero-address request that is not granted sees ready=0 and must hold valid/addr/data stable until accepted.
- Output stage (latency 1):
  - On the edge after a grant to i: wen_out=1, waddr_out=addr_i, wdata_out=data_i, wr_count_out increments by 1.
  - Without a grant: wen_out=0, waddr_out/wdata_out hold their last values.
  - The write lands in the regfile on the following edge.
- Priority update:
  - After any grant to i, prio becomes 1-i, including uncontended grants.
  - No grant leaves prio unchanged.
- Starvation bound: under continuous contention, grants strictly alternate, so each requester waits at most 1 cycle.
- Same destination from both requesters in one cycle: only the granted one is written that cycle. The other is written on the next grant, so the later write wins in the regfile.
- stall_in=1: no grants, ready=0 for all nonzero-address requests, wen_out=0 on the next edge, prio and counter unchanged.
- Counter: wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Reset: hold rst=0 for 2 cycles with both requests valid -> both readies stay 0 during reset; wen_out=0, wr_count_out=0, waddr_out=0, wdata_out=0 after release until a grant.
- Single request: req0 valid, addr=5, data=0xA5 for 1 cycle -> req0_ready_out=1 that cycle; next cycle wen_out=1, waddr_out=5, wdata_out=0xA5, wr_count_out=1; the cycle after, wen_out=0.
- Contention: both valid continuously with addr0=3/data0=0x11 and addr1=7/data1=0x22 from reset -> grants alternate req0, req1, req0, req1; waddr_out sequence 3,7,3,7 with matching data; wr_count_out=4 after 4 grants.
- x0 filter: req1 valid, addr=0, with stall_in=1 -> req1_ready_out=1, wen_out stays 0, wr_count_out and prio unchanged; req0 addr=0 and req1 addr=9 in the same cycle -> both ready, only write to 9 issued.
- Stall: both valid, nonzero addresses, stall_in=1 for 3 cycles, then 0 -> no ready and wen_out=0 for 3 cycles; first grant after the stall goes to the requester indicated by the pre-stall prio.
- Reset mid-operation: grant to req1 (addr=4) in the same cycle rst=0 -> next cycle wen_out=0, wr_count_out=0, prio=0; req1 must re-present, and is granted after reset release.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bundle between the two requesters (ALU, LSU) and the arbiter,
// plus the arbiter's registered drive of the int_regfile write port.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 64
);
  logic            req0_valid_in;
  logic [4:0]      req0_addr_in;
  logic [XLEN-1:0] req0_data_in;
  logic            req0_ready_out;

  logic            req1_valid_in;
  logic [4:0]      req1_addr_in;
  logic [XLEN-1:0] req1_data_in;
  logic            req1_ready_out;

  logic            wen_out;
  logic [4:0]      waddr_out;
  logic [XLEN-1:0] wdata_out;

  // Arbiter side.
  modport slave (
    input  req0_valid_in, req0_addr_in, req0_data_in,
    input  req1_valid_in, req1_addr_in, req1_data_in,
    output req0_ready_out, req1_ready_out,
    output wen_out, waddr_out, wdata_out
  );

  // Requester / regfile side.
  modport master (
    output req0_valid_in, req0_addr_in, req0_data_in,
    output req1_valid_in, req1_addr_in, req1_data_in,
    input  req0_ready_out, req1_ready_out,
    input  wen_out, waddr_out, wdata_out
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the int_regfile write port between ALU and LSU
// writeback; x0 writes are swallowed without a grant, the port is registered.
module regfile_wb_arbiter #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_in,
  regfile_wb_arbiter_if.slave  wb,
  output logic [CNT_W-1:0]     wr_count_out
);

  typedef enum logic {
    PRIO_REQ0 = 1'b0,
    PRIO_REQ1 = 1'b1
  } prio_e;

  prio_e            prio_q, prio_d;
  logic             wen_q, wen_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic elig0, elig1, zero0, zero1, gnt0, gnt1;

  // Nothing is accepted while reset is asserted, so a request presented in a
  // reset cycle must be re-presented after release.
  assign zero0 = rst && wb.req0_valid_in && (wb.req0_addr_in == 5'd0);
  assign zero1 = rst && wb.req1_valid_in && (wb.req1_addr_in == 5'd0);
  assign elig0 = rst && !stall_in && wb.req0_valid_in && (wb.req0_addr_in != 5'd0);
  assign elig1 = rst && !stall_in && wb.req1_valid_in && (wb.req1_addr_in != 5'd0);

  assign gnt0 = elig0 && (!elig1 || (prio_q == PRIO_REQ0));
  assign gnt1 = elig1 && (!elig0 || (prio_q == PRIO_REQ1));

  assign wb.req0_ready_out = gnt0 || zero0;
  assign wb.req1_ready_out = gnt1 || zero1;

  // NOTE: every next-state signal gets a default first so no path leaves it
  // unassigned; otherwise this always_comb would infer latches.
  always_comb begin
    prio_d  = prio_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    if (gnt0) begin
      prio_d  = PRIO_REQ1;
      wen_d   = 1'b1;
      waddr_d = wb.req0_addr_in;
      wdata_d = wb.req0_data_in;
      cnt_d   = cnt_q + 1'b1;
    end else if (gnt1) begin
      prio_d  = PRIO_REQ0;
      wen_d   = 1'b1;
      waddr_d = wb.req1_addr_in;
      wdata_d = wb.req1_data_in;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update
  // together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_q  <= PRIO_REQ0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      prio_q  <= prio_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb.wen_out   = wen_q;
  assign wb.waddr_out = waddr_q;
  assign wb.wdata_out = wdata_q;
  assign wr_count_out = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, round-robin
// contention, x0 filtering, stall hold, same-destination and mid-run reset.
module tb_regfile_wb_arbiter;
  localparam int XLEN  = 64;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic [CNT_W-1:0] cnt;
  int               n_checks = 0;
  int               n_fail   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(XLEN)) wb ();

  regfile_wb_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_in     (stall),
    .wb           (wb),
    .wr_count_out (cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic req0(input logic v, input logic [4:0] a, input logic [63:0] d);
    wb.req0_valid_in = v;
    wb.req0_addr_in  = a;
    wb.req0_data_in  = d;
  endtask

  task automatic req1(input logic v, input logic [4:0] a, input logic [63:0] d);
    wb.req1_valid_in = v;
    wb.req1_addr_in  = a;
    wb.req1_data_in  = d;
  endtask

  // Ready is combinational: sample it 1 time unit after inputs settle.
  task automatic expect_rdy(input string tag, input logic r0, input logic r1);
    #1;
    check({tag, ".rdy0"}, 64'(wb.req0_ready_out), 64'(r0));
    check({tag, ".rdy1"}, 64'(wb.req1_ready_out), 64'(r1));
  endtask

  // Advance one edge, then sample the registered write port.
  task automatic expect_out(input string tag, input logic wen, input logic [4:0] wa,
                            input logic [63:0] wd, input logic [31:0] c);
    @(posedge clk);
    #1;
    check({tag, ".wen"},   64'(wb.wen_out),   64'(wen));
    check({tag, ".waddr"}, 64'(wb.waddr_out), 64'(wa));
    check({tag, ".wdata"}, wb.wdata_out,      wd);
    check({tag, ".cnt"},   64'(cnt),          64'(c));
  endtask

  initial begin
    rst   = 1'b0;
    stall = 1'b0;
    req0(1'b1, 5'd3, 64'h11);
    req1(1'b1, 5'd7, 64'h22);

    // Reset held two cycles with both requests valid.
    expect_rdy("rst_c0", 1'b0, 1'b0);
    expect_out("rst_c0", 1'b0, 5'd0, 64'h0, 0);
    expect_rdy("rst_c1", 1'b0, 1'b0);
    expect_out("rst_c1", 1'b0, 5'd0, 64'h0, 0);

    // Continuous contention: strict alternation starting with req0.
    rst = 1'b1;
    expect_rdy("cont1", 1'b1, 1'b0);
    expect_out("cont1", 1'b1, 5'd3, 64'h11, 1);
    expect_rdy("cont2", 1'b0, 1'b1);
    expect_out("cont2", 1'b1, 5'd7, 64'h22, 2);
    expect_rdy("cont3", 1'b1, 1'b0);
    expect_out("cont3", 1'b1, 5'd3, 64'h11, 3);
    expect_rdy("cont4", 1'b0, 1'b1);
    expect_out("cont4", 1'b1, 5'd7, 64'h22, 4);

    // Idle: wen drops, address/data hold.
    req0(1'b0, 5'd3, 64'h11);
    req1(1'b0, 5'd7, 64'h22);
    expect_rdy("idle", 1'b0, 1'b0);
    expect_out("idle", 1'b0, 5'd7, 64'h22, 4);

    // Single uncontended request; prio moves to req1.
    req0(1'b1, 5'd5, 64'hA5);
    expect_rdy("single", 1'b1, 1'b0);
    expect_out("single", 1'b1, 5'd5, 64'hA5, 5);
    req0(1'b0, 5'd5, 64'hA5);
    expect_out("single_after", 1'b0, 5'd5, 64'hA5, 5);

    // x0 request accepted under stall, no write, prio untouched.
    stall = 1'b1;
    req1(1'b1, 5'd0, 64'hDEAD);
    expect_rdy("x0_stall", 1'b0, 1'b1);
    expect_out("x0_stall", 1'b0, 5'd5, 64'hA5, 5);

    // prio still req1, so contention goes to req1.
    stall = 1'b0;
    req0(1'b1, 5'd3, 64'h11);
    req1(1'b1, 5'd7, 64'h22);
    expect_rdy("prio_kept", 1'b0, 1'b1);
    expect_out("prio_kept", 1'b1, 5'd7, 64'h22, 6);

    // req0 to x0 and req1 to x9 together: both ready, only x9 written.
    req0(1'b1, 5'd0, 64'h77);
    req1(1'b1, 5'd9, 64'h99);
    expect_rdy("x0_mix", 1'b1, 1'b1);
    expect_out("x0_mix", 1'b1, 5'd9, 64'h99, 7);

    // Stall for 3 cycles with contention; prio is req0 going in.
    stall = 1'b1;
    req0(1'b1, 5'd3, 64'h11);
    req1(1'b1, 5'd7, 64'h22);
    for (int i = 0; i < 3; i++) begin
      expect_rdy("stall", 1'b0, 1'b0);
      expect_out("stall", 1'b0, 5'd9, 64'h99, 7);
    end
    stall = 1'b0;
    expect_rdy("post_stall", 1'b1, 1'b0);
    expect_out("post_stall", 1'b1, 5'd3, 64'h11, 8);

    // Same destination from both: req1 (prio) first, req0 later wins.
    req0(1'b1, 5'd12, 64'hAA);
    req1(1'b1, 5'd12, 64'hBB);
    expect_rdy("same_a", 1'b0, 1'b1);
    expect_out("same_a", 1'b1, 5'd12, 64'hBB, 9);
    req1(1'b0, 5'd12, 64'hBB);
    expect_rdy("same_b", 1'b1, 1'b0);
    expect_out("same_b", 1'b1, 5'd12, 64'hAA, 10);

    // Reset mid-operation with prio=req1: request dropped, state cleared.
    req0(1'b0, 5'd0, 64'h0);
    req1(1'b1, 5'd4, 64'h44);
    rst = 1'b0;
    expect_rdy("mid_rst", 1'b0, 1'b0);
    expect_out("mid_rst", 1'b0, 5'd0, 64'h0, 0);

    // After release prio is req0 again; req1 re-presents and follows.
    rst = 1'b1;
    req0(1'b1, 5'd3, 64'h11);
    expect_rdy("rel_a", 1'b1, 1'b0);
    expect_out("rel_a", 1'b1, 5'd3, 64'h11, 1);
    req0(1'b0, 5'd3, 64'h11);
    expect_rdy("rel_b", 1'b0, 1'b1);
    expect_out("rel_b", 1'b1, 5'd4, 64'h44, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
